// File: rtl/hex_seg_scan.sv
// hex_seg_scan: time-multiplexed hexadecimal seven-segment display driver.
// A packed nibble word arrives over valid/ready and waits in a one-word
// pending buffer. It moves into the display register only at a frame
// boundary, so a shown value never tears. Each digit slot opens with a
// blanking gap for de-ghosting and then lights one digit.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module hex_seg_scan #(
    parameter int DIGITS       = 2,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW    = 4 * DIGITS;

    // Segment pattern a..g with dp = 0, active-high.
    function automatic logic [7:0] hex_encode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = 8'b11111100;
            4'h1: pat = 8'b01100000;
            4'h2: pat = 8'b11011010;
            4'h3: pat = 8'b11110010;
            4'h4: pat = 8'b01100110;
            4'h5: pat = 8'b10110110;
            4'h6: pat = 8'b10111110;
            4'h7: pat = 8'b11100000;
            4'h8: pat = 8'b11111110;
            4'h9: pat = 8'b11110110;
            4'hA: pat = 8'b11101110;
            4'hB: pat = 8'b00111110;
            4'hC: pat = 8'b10011100;
            4'hD: pat = 8'b01111010;
            4'hE: pat = 8'b10011110;
            default: pat = 8'b10001110;
        endcase
        return pat;
    endfunction

    logic [DIV_W-1:0]  div;
    logic [IDX_W-1:0]  idx;
    logic [DW-1:0]     disp;
    logic [DW-1:0]     pend;
    logic              pend_full;
    logic              slot_end;
    logic              frame_end;
    logic              accept;
    logic              lit;
    logic [3:0]        cur_nib;
    logic [DIGITS-1:0] lz_blank;

    assign slot_end  = (div == DIV_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));
    assign in_ready  = !pend_full;
    assign accept    = in_valid && !pend_full;
    assign lit       = (div >= DIV_W'(BLANK_CYCLES));
    assign cur_nib   = disp[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // A digit above 0 is blanked when it and every more-significant nibble are zero.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (disp[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Slot divider and digit index; idx advances at each slot end and wraps per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (slot_end) begin
            div <= '0;
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Pending-buffer flag and display register; commit only at frame end, no bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full <= 1'b0;
            disp      <= '0;
        end else begin
            if (frame_end && pend_full) begin
                disp      <= pend;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend_full <= 1'b1;
            end
        end
    end

    // Pending word capture on an accepted transfer.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend <= in_data;
        end
    end

    // Registered digit enable and segments, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '0;
            seg <= '0;
        end else if (lit && !lz_blank[idx]) begin
            an  <= DIGITS'(1) << idx;
            seg <= hex_encode(cur_nib);
        end else begin
            an  <= '0;
            seg <= '0;
        end
    end

endmodule
